// File: rtl/touch_pkg.sv
// Shared types, panel defaults and the coordinate calibration helper for the
// touch conditioning path.
package touch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } touch_state_e;

  localparam int unsigned NO_TOUCH_DEF = 1000;
  localparam int unsigned SCREEN_W_DEF = 480;
  localparam int unsigned SCREEN_H_DEF = 272;

  // Offset with saturation at zero, then shift, then clamp to the panel edge.
  function automatic int unsigned calib(input int unsigned avg,
                                        input int unsigned offset,
                                        input int unsigned shift,
                                        input int unsigned limit);
    int unsigned c;
    c = (avg < offset) ? 0 : ((avg - offset) >> shift);
    return (c > limit) ? limit : c;
  endfunction

endpackage

// File: rtl/touch_axis_avg.sv
// One coordinate axis: accumulates accepted samples and, when the shared
// count wraps, stores the calibrated average as the pending coordinate.
module touch_axis_avg
  import touch_pkg::*;
#(
  parameter int unsigned RAW_W    = 12,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned OFFSET   = 150,
  parameter int unsigned SHIFT    = 3,
  parameter int unsigned LIMIT    = 479
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RAW_W-1:0] sample_i,
  input  logic             acc_en_i,
  input  logic             done_i,
  input  logic             clear_i,
  output logic [RAW_W-1:0] pend_o
);

  localparam int unsigned ACC_W = RAW_W + AVG_LOG2;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [RAW_W-1:0] pend_q, pend_d;
  logic [ACC_W-1:0] sum;
  logic [RAW_W-1:0] avg;

  // The sample completing an average is folded in before dividing.
  assign sum = acc_q + ACC_W'(sample_i);
  assign avg = sum[ACC_W-1:AVG_LOG2];

  always_comb begin
    acc_d  = acc_q;
    pend_d = pend_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (done_i) begin
      acc_d  = '0;
      pend_d = RAW_W'(calib(32'(avg), OFFSET, SHIFT, LIMIT));
    end else if (acc_en_i) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      pend_q <= '0;
    end else begin
      acc_q  <= acc_d;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/touch_calibrator.sv
// Debounced press detection, averaging and frame-synchronous publication of
// calibrated touch coordinates.
module touch_calibrator
  import touch_pkg::*;
#(
  parameter int unsigned RAW_W    = 12,
  parameter int unsigned X_OFFSET = 150,
  parameter int unsigned Y_OFFSET = 300,
  parameter int unsigned X_SHIFT  = 3,
  parameter int unsigned Y_SHIFT  = 4,
  parameter int unsigned Z_THRESH = 256,
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned SCREEN_W = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H = SCREEN_H_DEF,
  parameter int unsigned NO_TOUCH = NO_TOUCH_DEF
) (
  input  logic             cclk,
  input  logic             rstb,
  input  logic [RAW_W-1:0] raw_x,
  input  logic [RAW_W-1:0] raw_y,
  input  logic [RAW_W-1:0] raw_z,
  input  logic             sample_valid,
  input  logic             new_frame,
  output logic [RAW_W-1:0] touch_x,
  output logic [RAW_W-1:0] touch_y,
  output logic             touch_pressed,
  output logic             touch_update
);

  localparam int unsigned DCNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int unsigned CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [DCNT_W-1:0] DEB_LAST   = DCNT_W'(DEBOUNCE - 1);
  localparam logic [RAW_W-1:0]  NO_TOUCH_V = RAW_W'(NO_TOUCH);

  touch_state_e      state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              avg_done_q, avg_done_d;
  logic [RAW_W-1:0]  touch_x_q, touch_y_q;
  logic              touch_pressed_q, touch_update_q;

  logic             hit, acc_en, avg_strobe, clear, pend_pressed, changed;
  logic [RAW_W-1:0] pend_x, pend_y, pub_x, pub_y;

  assign hit = (32'(raw_z) >= Z_THRESH);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    if (sample_valid) begin
      case (state_q)
        IDLE: if (hit) begin
          if (DEBOUNCE == 1) begin state_d = PRESSED; dcnt_d = '0; end
          else begin state_d = PRESS_PEND; dcnt_d = DCNT_W'(1); end
        end
        PRESS_PEND: begin
          if (!hit) begin state_d = IDLE; dcnt_d = '0; end
          else if (dcnt_q == DEB_LAST) begin state_d = PRESSED; dcnt_d = '0; end
          else dcnt_d = dcnt_q + DCNT_W'(1);
        end
        PRESSED: if (!hit) begin
          if (DEBOUNCE == 1) begin state_d = IDLE; dcnt_d = '0; end
          else begin state_d = RELEASE_PEND; dcnt_d = DCNT_W'(1); end
        end
        RELEASE_PEND: begin
          if (hit) begin state_d = PRESSED; dcnt_d = '0; end
          else if (dcnt_q == DEB_LAST) begin state_d = IDLE; dcnt_d = '0; end
          else dcnt_d = dcnt_q + DCNT_W'(1);
        end
        default: begin state_d = IDLE; dcnt_d = '0; end
      endcase
    end
  end

  // A hit seen in RELEASE_PEND returns to PRESSED, so it is averaged too.
  assign acc_en     = sample_valid && hit && (state_q == PRESSED || state_q == RELEASE_PEND);
  assign avg_strobe = acc_en && ((AVG_LOG2 == 0) || (&cnt_q));
  assign clear      = (state_d == IDLE);

  always_comb begin
    cnt_d      = cnt_q;
    avg_done_d = avg_done_q;
    if (clear) begin
      cnt_d      = '0;
      avg_done_d = 1'b0;
    end else begin
      if (acc_en && AVG_LOG2 != 0) cnt_d = cnt_q + CNT_W'(1);
      if (avg_strobe) avg_done_d = 1'b1;
    end
  end

  touch_axis_avg #(
    .RAW_W(RAW_W), .AVG_LOG2(AVG_LOG2), .OFFSET(X_OFFSET), .SHIFT(X_SHIFT), .LIMIT(SCREEN_W - 1)
  ) u_axis_x (
    .clk(cclk), .rst_n(rstb), .sample_i(raw_x), .acc_en_i(acc_en),
    .done_i(avg_strobe), .clear_i(clear), .pend_o(pend_x)
  );

  touch_axis_avg #(
    .RAW_W(RAW_W), .AVG_LOG2(AVG_LOG2), .OFFSET(Y_OFFSET), .SHIFT(Y_SHIFT), .LIMIT(SCREEN_H - 1)
  ) u_axis_y (
    .clk(cclk), .rst_n(rstb), .sample_i(raw_y), .acc_en_i(acc_en),
    .done_i(avg_strobe), .clear_i(clear), .pend_o(pend_y)
  );

  // Publication reads the pre-update state, so a coincident sample shows next frame.
  assign pend_pressed = (state_q == PRESSED) || (state_q == RELEASE_PEND);
  assign pub_x   = (pend_pressed && avg_done_q) ? pend_x : NO_TOUCH_V;
  assign pub_y   = (pend_pressed && avg_done_q) ? pend_y : NO_TOUCH_V;
  assign changed = (pub_x != touch_x_q) || (pub_y != touch_y_q) ||
                   (pend_pressed != touch_pressed_q);

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state_q         <= IDLE;
      dcnt_q          <= '0;
      cnt_q           <= '0;
      avg_done_q      <= 1'b0;
      touch_x_q       <= NO_TOUCH_V;
      touch_y_q       <= NO_TOUCH_V;
      touch_pressed_q <= 1'b0;
      touch_update_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      dcnt_q         <= dcnt_d;
      cnt_q          <= cnt_d;
      avg_done_q     <= avg_done_d;
      touch_update_q <= new_frame && changed;
      if (new_frame) begin
        touch_x_q       <= pub_x;
        touch_y_q       <= pub_y;
        touch_pressed_q <= pend_pressed;
      end
    end
  end

  assign touch_x       = touch_x_q;
  assign touch_y       = touch_y_q;
  assign touch_pressed = touch_pressed_q;
  assign touch_update  = touch_update_q;

endmodule

// File: tb/tb_touch_calibrator.sv
// Directed and randomized checks of touch_calibrator against a sample-level
// behavioural model of debounce, averaging and frame publication.
module tb_touch_calibrator;

  logic        cclk = 1'b0;
  logic        rstb;
  logic [11:0] raw_x, raw_y, raw_z;
  logic        sample_valid, new_frame;
  logic [11:0] touch_x, touch_y;
  logic        touch_pressed, touch_update;

  int passed = 0;
  int total  = 0;

  // Model: press state, run of samples disagreeing with it, pending averages.
  bit m_pressed;
  int m_streak;
  int qx[$];
  int qy[$];
  int m_pend_x, m_pend_y;
  bit m_avg_valid;
  int e_x, e_y;
  bit e_p, e_upd;

  touch_calibrator dut (
    .cclk(cclk), .rstb(rstb), .raw_x(raw_x), .raw_y(raw_y), .raw_z(raw_z),
    .sample_valid(sample_valid), .new_frame(new_frame),
    .touch_x(touch_x), .touch_y(touch_y),
    .touch_pressed(touch_pressed), .touch_update(touch_update)
  );

  always #5 cclk = ~cclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int cal(input int avg, input int off, input int sh, input int lim);
    int c;
    if (avg < off) return 0;
    c = (avg - off) / (2 ** sh);
    return (c > lim) ? lim : c;
  endfunction

  task automatic model_reset();
    m_pressed = 0; m_streak = 0; qx.delete(); qy.delete();
    m_pend_x = 0; m_pend_y = 0; m_avg_valid = 0;
    e_x = 1000; e_y = 1000; e_p = 0; e_upd = 0;
  endtask

  task automatic model_sample(input int x, input int y, input int z);
    bit hit;
    int sx, sy;
    hit = (z >= 256);
    if (m_pressed && hit) begin
      qx.push_back(x);
      qy.push_back(y);
      if (qx.size() == 4) begin
        sx = 0; sy = 0;
        foreach (qx[i]) begin sx += qx[i]; sy += qy[i]; end
        m_pend_x = cal(sx / 4, 150, 3, 479);
        m_pend_y = cal(sy / 4, 300, 4, 271);
        m_avg_valid = 1;
        qx.delete(); qy.delete();
      end
    end
    if (hit != m_pressed) begin
      m_streak++;
      if (m_streak >= 3) begin
        m_pressed = hit;
        m_streak = 0;
        if (!hit) begin qx.delete(); qy.delete(); m_avg_valid = 0; end
      end
    end else begin
      m_streak = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".x"}, 32'(touch_x), e_x);
    check({tag, ".y"}, 32'(touch_y), e_y);
    check({tag, ".pressed"}, 32'(touch_pressed), 32'(e_p));
    check({tag, ".update"}, 32'(touch_update), 32'(e_upd));
  endtask

  task automatic step(input string tag, input bit sv, input int x, input int y,
                      input int z, input bit nf);
    int nx, ny;
    @(negedge cclk);
    sample_valid = sv; new_frame = nf;
    raw_x = 12'(x); raw_y = 12'(y); raw_z = 12'(z);
    if (nf) begin
      nx = (m_pressed && m_avg_valid) ? m_pend_x : 1000;
      ny = (m_pressed && m_avg_valid) ? m_pend_y : 1000;
      e_upd = (nx != e_x) || (ny != e_y) || (m_pressed != e_p);
      e_x = nx; e_y = ny; e_p = m_pressed;
    end else begin
      e_upd = 0;
    end
    if (sv) model_sample(x, y, z);
    @(posedge cclk);
    #1;
    check_outputs(tag);
    sample_valid = 0; new_frame = 0;
  endtask

  initial begin
    bit want;
    int z;
    rstb = 1; sample_valid = 0; new_frame = 0; raw_x = 0; raw_y = 0; raw_z = 0;
    model_reset();
    #1 rstb = 0;
    #2 check_outputs("reset");
    repeat (2) @(negedge cclk);
    rstb = 1;

    step("idle_frame", 0, 0, 0, 0, 1);
    // Press, then four averaged samples: expect 200/162.
    repeat (3) step("press", 1, 1750, 2900, 'h300, 0);
    repeat (4) step("avg", 1, 1750, 2900, 'h300, 0);
    step("pub_avg", 0, 0, 0, 0, 1);
    check("pub_avg.x_const", 32'(touch_x), 200);
    check("pub_avg.y_const", 32'(touch_y), 162);
    step("pub_hold", 0, 0, 0, 0, 1);
    // Clamp on x, saturate on y.
    repeat (4) step("clamp", 1, 4095, 100, 'h300, 0);
    step("pub_clamp", 0, 0, 0, 0, 1);
    check("pub_clamp.x_const", 32'(touch_x), 479);
    check("pub_clamp.y_const", 32'(touch_y), 0);
    // Release.
    repeat (3) step("release", 1, 0, 0, 'h0FF, 0);
    step("pub_release", 0, 0, 0, 0, 1);
    // Glitch rejection.
    step("glitch_frame", 0, 0, 0, 0, 1);
    repeat (2) step("glitch_hit", 1, 500, 500, 'h300, 0);
    step("glitch_miss", 1, 500, 500, 'h0FF, 0);
    step("glitch_frame2", 0, 0, 0, 0, 1);
    repeat (3) step("glitch_hit2", 1, 500, 500, 'h300, 1);
    // Simultaneous strobes.
    repeat (3) step("sim_press", 1, 1750, 2900, 'h300, 0);
    step("sim_frame0", 0, 0, 0, 0, 1);
    repeat (3) step("sim_avg", 1, 1000, 1000, 'h300, 0);
    step("sim_both", 1, 1000, 1000, 'h300, 1);
    step("sim_next", 0, 0, 0, 0, 1);
    // Partial average, then asynchronous reset mid-cycle.
    repeat (2) step("partial", 1, 2000, 2000, 'h300, 0);
    @(posedge cclk);
    #2 rstb = 0;
    #1;
    model_reset();
    check("async_rst.x", 32'(touch_x), 1000);
    check("async_rst.y", 32'(touch_y), 1000);
    check("async_rst.pressed", 32'(touch_pressed), 0);
    @(negedge cclk);
    rstb = 1;
    step("post_rst_frame", 0, 0, 0, 0, 1);
    repeat (3) step("repress", 1, 1750, 2900, 'h300, 0);
    repeat (3) step("refill", 1, 1750, 2900, 'h300, 0);
    step("refill_frame", 0, 0, 0, 0, 1);
    step("refill_last", 1, 1750, 2900, 'h300, 0);
    step("refill_pub", 0, 0, 0, 0, 1);

    // Randomized phase.
    want = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) want = ~want;
      z = want ? int'($urandom_range(256, 4095)) : int'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) z = want ? 255 : 256;
      step("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 4095)),
           int'($urandom_range(0, 4095)), z, ($urandom_range(0, 4) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
